// File: rtl/bcd_updown_counter_n.sv
// N-digit BCD up/down counter with synchronous load, enable, and wrap or saturate
// at the limits. Provides a registered terminal-count pulse and a zero flag.
module bcd_updown_counter_n #(
  parameter int DIGITS = 2,
  parameter int WRAP   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  cuenta,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  tc,
  output logic                  is_zero
);

  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic                tc_q, tc_d;
  logic                zero_q, zero_d;
  logic                allNine, allZero;

  always_comb begin
    allNine = 1'b1;
    allZero = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_q[4*k +: 4] != 4'd9) allNine = 1'b0;
      if (bcd_q[4*k +: 4] != 4'd0) allZero = 1'b0;
    end
  end

  // Next-state: load clamps each digit to 9; counting ripples carry/borrow
  // through the digit chain within one cycle.
  always_comb begin
    logic carry;
    bcd_d  = bcd_q;
    tc_d   = 1'b0;
    carry  = 1'b1;
    if (load) begin
      for (int k = 0; k < DIGITS; k++) begin
        if (load_val[4*k +: 4] > 4'd9) bcd_d[4*k +: 4] = 4'd9;
        else                           bcd_d[4*k +: 4] = load_val[4*k +: 4];
      end
    end else if (en) begin
      if (cuenta) begin
        if (allNine) begin
          tc_d = 1'b1;
          if (WRAP != 0) bcd_d = '0;
        end else begin
          for (int k = 0; k < DIGITS; k++) begin
            if (carry) begin
              if (bcd_q[4*k +: 4] == 4'd9) begin
                bcd_d[4*k +: 4] = 4'd0;
              end else begin
                bcd_d[4*k +: 4] = bcd_q[4*k +: 4] + 4'd1;
                carry = 1'b0;
              end
            end
          end
        end
      end else begin
        if (allZero) begin
          tc_d = 1'b1;
          if (WRAP != 0) bcd_d = {DIGITS{4'd9}};
        end else begin
          for (int k = 0; k < DIGITS; k++) begin
            if (carry) begin
              if (bcd_q[4*k +: 4] == 4'd0) begin
                bcd_d[4*k +: 4] = 4'd9;
              end else begin
                bcd_d[4*k +: 4] = bcd_q[4*k +: 4] - 4'd1;
                carry = 1'b0;
              end
            end
          end
        end
      end
    end
    zero_d = (bcd_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_q  <= '0;
      tc_q   <= 1'b0;
      zero_q <= 1'b1;
    end else begin
      bcd_q  <= bcd_d;
      tc_q   <= tc_d;
      zero_q <= zero_d;
    end
  end

  assign bcd     = bcd_q;
  assign tc      = tc_q;
  assign is_zero = zero_q;

endmodule
